crc7_enc_scheduler: RTL

Multi-requester front end for the 16-bit-message CRC-7 encoder (polynomial 0x89, x^7+x^3+1).
- Accepts 16-bit words from NREQ requesters and picks one with a round-robin arbiter.
- Sequences the encoder's en_data / en_crc controls and waits for crc_ready.
- Returns the 23-bit codeword and 7-bit CRC, tagged with the requester index, over a valid/ready response port.
- Sits between client blocks and the single shared encoder instance.

---
 rtl/crc7_enc_scheduler_if.sv | 33 +++
 rtl/crc7_enc_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/crc7_enc_scheduler_if.sv
// Request, encoder-control and response bundle for crc7_enc_scheduler.
// master = clients plus shared encoder, slave = scheduler.
interface crc7_enc_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_data;
  logic [15:0]          enc_data_in;
  logic                 enc_en_data;
  logic                 enc_en_crc;
  logic                 enc_crc_ready;
  logic [22:0]          enc_data_out;
  logic [6:0]           enc_crc_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [22:0]          rsp_codeword;
  logic [6:0]           rsp_crc;

  modport master (
    output req_valid, req_data, rsp_ready, enc_crc_ready, enc_data_out, enc_crc_out,
    input  req_ready, enc_data_in, enc_en_data, enc_en_crc,
           rsp_valid, rsp_id, rsp_codeword, rsp_crc
  );

  modport slave (
    input  req_valid, req_data, rsp_ready, enc_crc_ready, enc_data_out, enc_crc_out,
    output req_ready, enc_data_in, enc_en_data, enc_en_crc,
           rsp_valid, rsp_id, rsp_codeword, rsp_crc
  );
endinterface

// File: rtl/crc7_enc_scheduler.sv
// Round-robin front end sequencing one shared 16-bit CRC-7 encoder for NREQ clients.
// Optional WAIT_RDY abort enabled by defining CRC7_TIMEOUT_EN.
module crc7_enc_scheduler #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned IDW            = 2,
  parameter int unsigned SHIFT_CYCLES   = 15,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  crc7_enc_scheduler_if.slave  bus,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int unsigned CNT_W = $clog2(SHIFT_CYCLES + 1);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || SHIFT_CYCLES == 0 || TIMEOUT_CYCLES == 0)
  begin : g_bad_params
    $error("crc7_enc_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, CAPTURE, WAIT_RDY, RESPOND
  } state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [IDW-1:0]    ptr_q, ptr_nxt;
  logic [IDW-1:0]    id_q, id_nxt;
  logic [15:0]       hold_q, hold_nxt;
  logic              en_data_q, en_data_nxt;
  logic              en_crc_q, en_crc_nxt;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic [22:0]       cw_q, cw_nxt;
  logic [6:0]        crc_q, crc_nxt;
  logic              busy_q, busy_nxt;
  logic [NREQ-1:0]   req_ready_c;

  logic [15:0]       words [NREQ];
  logic              grant_valid;
  logic [IDW-1:0]    grant_idx;
  logic              hi_found;
  logic [IDW-1:0]    hi_idx, lo_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = bus.req_data[16*g +: 16];
  end

  // Lowest valid index at/after the pointer, else lowest valid index overall (wrap).
  always_comb begin
    grant_valid = 1'b0;
    hi_found    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        grant_valid = 1'b1;
        lo_idx      = IDW'(k);
        if (IDW'(k) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(k);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

`ifdef CRC7_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic             err_q, err_nxt;
`endif

  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    ptr_nxt       = ptr_q;
    id_nxt        = id_q;
    hold_nxt      = hold_q;
    rsp_valid_nxt = rsp_valid_q;
    cw_nxt        = cw_q;
    crc_nxt       = crc_q;
    req_ready_c   = '0;
`ifdef CRC7_TIMEOUT_EN
    tmo_nxt       = tmo_q;
    err_nxt       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Stale enc_crc_ready is deliberately not looked at here.
        if (grant_valid) begin
          req_ready_c = NREQ'(1) << grant_idx;
          hold_nxt    = words[grant_idx];
          id_nxt      = grant_idx;
          ptr_nxt     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        cnt_nxt = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SHIFT_CYCLES - 1)) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = WAIT_RDY;
`ifdef CRC7_TIMEOUT_EN
        tmo_nxt   = '0;
`endif
      end
      WAIT_RDY: begin
        if (bus.enc_crc_ready) begin
          cw_nxt        = bus.enc_data_out;
          crc_nxt       = bus.enc_crc_out;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESPOND;
        end
`ifdef CRC7_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_q + 1'b1;
        end
`endif
      end
      RESPOND: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    en_data_nxt = (state_nxt == LOAD);
    en_crc_nxt  = (state_nxt == SHIFT);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      hold_q      <= '0;
      en_data_q   <= 1'b0;
      en_crc_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cw_q        <= '0;
      crc_q       <= '0;
      busy_q      <= 1'b0;
`ifdef CRC7_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      ptr_q       <= ptr_nxt;
      id_q        <= id_nxt;
      hold_q      <= hold_nxt;
      en_data_q   <= en_data_nxt;
      en_crc_q    <= en_crc_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      cw_q        <= cw_nxt;
      crc_q       <= crc_nxt;
      busy_q      <= busy_nxt;
`ifdef CRC7_TIMEOUT_EN
      tmo_q       <= tmo_nxt;
      err_q       <= err_nxt;
`endif
    end
  end

  // Accept strobe must coincide with the grant cycle, so it is decoded, not registered.
  assign bus.req_ready    = reset ? '0 : req_ready_c;
  assign bus.enc_data_in  = hold_q;
  assign bus.enc_en_data  = en_data_q;
  assign bus.enc_en_crc   = en_crc_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_codeword = cw_q;
  assign bus.rsp_crc      = crc_q;
  assign busy             = busy_q;
`ifdef CRC7_TIMEOUT_EN
  assign err_timeout      = err_q;
`else
  assign err_timeout      = 1'b0;
`endif

endmodule
